// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one sequential 8x8 multiplier among NREQ clients.
// One operation in flight at a time: grant/load, wait for ready (or time out), return the product.
module mul_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [15:0]         result,
    output logic                timeout_err,
    output logic                busy,
    output logic                mul_load,
    output logic [7:0]          mul_a,
    output logic [7:0]          mul_b,
    input  logic                mul_ready,
    input  logic [15:0]         mul_product
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   next_ptr;
    logic [PW-1:0]   win_idx;
    logic            win_valid;
    logic [PW:0]     cand;
    logic [CW-1:0]   wait_cnt;
    logic            ready_hit;
    logic            timed_out;

    logic [NREQ-1:0] gnt_d;
    logic [NREQ-1:0] done_d;
    logic            terr_d;
    logic            busy_d;
    logic            load_d;

    // Rotating-priority scan starting at rr_ptr; cand wraps modulo NREQ.
    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!win_valid && req[cand[PW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    assign next_ptr = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;

    // The first WAIT cycle (wait_cnt == 0) ignores ready left over from a previous operation.
    assign ready_hit = (state == WAIT) && (wait_cnt != '0) && mul_ready;
    assign timed_out = (state == WAIT) && !ready_hit && (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (win_valid) state_next = LOAD;
            LOAD: state_next = WAIT;
            WAIT: if (ready_hit || timed_out) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered, so their D-side is decoded from the state being entered.
    always_comb begin
        gnt_d  = '0;
        done_d = '0;
        terr_d = 1'b0;
        busy_d = (state_next != IDLE);
        load_d = (state_next == LOAD);
        if (state_next == LOAD) begin
            gnt_d = NREQ'(1) << win_idx;
        end
        if (state_next == DONE) begin
            done_d = NREQ'(1) << winner;
            terr_d = timed_out;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            winner      <= '0;
            wait_cnt    <= '0;
            gnt         <= '0;
            done        <= '0;
            result      <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            mul_load    <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
        end else begin
            state       <= state_next;
            gnt         <= gnt_d;
            done        <= done_d;
            timeout_err <= terr_d;
            busy        <= busy_d;
            mul_load    <= load_d;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        winner <= win_idx;
                        mul_a  <= req_a[8*win_idx +: 8];
                        mul_b  <= req_b[8*win_idx +: 8];
                    end
                end
                LOAD: begin
                    rr_ptr   <= next_ptr;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (ready_hit) begin
                        result <= mul_product;
                    end else if (timed_out) begin
                        result <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Structural invariants of the handshake.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(done));
    a_terr_done  : assert property (@(posedge clk) disable iff (rst) timeout_err |-> (done != '0));
    a_load_gnt   : assert property (@(posedge clk) disable iff (rst) mul_load == (gnt != '0));

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized bench for mul_share_arbiter: a transaction-level model predicts every output each cycle.
module tb_mul_share_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int NCYC    = 8000;

    typedef enum int {M_NORMAL, M_STALE, M_HANG} mul_mode_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   req_a;
    logic [8*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [15:0]         result;
    logic                timeout_err;
    logic                busy;
    logic                mul_load;
    logic [7:0]          mul_a;
    logic [7:0]          mul_b;
    logic                mul_ready;
    logic [15:0]         mul_product;

    always #5 clk = ~clk;

    mul_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_a       (req_a),
        .req_b       (req_b),
        .gnt         (gnt),
        .done        (done),
        .result      (result),
        .timeout_err (timeout_err),
        .busy        (busy),
        .mul_load    (mul_load),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_ready   (mul_ready),
        .mul_product (mul_product)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: tracks one operation as "edges since arbitration".
    bit              m_active = 1'b0;
    int              m_ptr = 0, m_w = 0, m_j = 0, m_fin = 0;
    logic [NREQ-1:0] e_gnt, e_done;
    logic [15:0]     e_result;
    logic            e_terr, e_busy, e_load;
    logic [7:0]      e_a, e_b;

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        int n;
        if (rst) begin
            m_active = 1'b0;
            m_ptr    = 0;
            e_gnt = '0; e_done = '0; e_result = '0; e_terr = 1'b0;
            e_busy = 1'b0; e_load = 1'b0; e_a = '0; e_b = '0;
        end else if (!m_active) begin
            e_gnt = '0; e_done = '0; e_terr = 1'b0; e_load = 1'b0; e_busy = 1'b0;
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_active = 1'b1;
                m_w   = w;
                m_j   = 0;
                m_fin = 0;
                e_a   = req_a[8*w +: 8];
                e_b   = req_b[8*w +: 8];
                e_load = 1'b1;
                e_gnt  = NREQ'(1) << w;
                e_busy = 1'b1;
            end
        end else begin
            m_j++;
            if (m_j == 1) begin
                e_load = 1'b0;
                e_gnt  = '0;
                m_ptr  = (m_w + 1) % NREQ;
            end else if (m_fin == 0) begin
                n = m_j - 1;  // index of this WAIT edge, starting at 1
                if (n >= 2 && mul_ready) begin
                    e_result = mul_product;
                    e_done   = NREQ'(1) << m_w;
                    m_fin    = m_j;
                end else if (n == TIMEOUT) begin
                    e_result = '0;
                    e_terr   = 1'b1;
                    e_done   = NREQ'(1) << m_w;
                    m_fin    = m_j;
                end
            end else begin
                e_done   = '0;
                e_terr   = 1'b0;
                e_busy   = 1'b0;
                m_active = 1'b0;
            end
        end
    endtask

    // Behavioural sequential multiplier driven by the DUT's load strobe.
    mul_mode_t mode = M_NORMAL;
    int        mul_cnt = 0;
    int        fixed_lat = -1;
    logic [15:0] prod = '0;

    task automatic mul_step();
        if (mul_load) begin
            prod    = 16'(mul_a) * 16'(mul_b);
            mul_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 10));
        end else if (mul_cnt > 0) begin
            mul_cnt--;
        end
        case (mode)
            M_STALE: mul_ready = 1'b1;
            M_HANG:  mul_ready = 1'b0;
            default: mul_ready = (mul_cnt == 0) && !mul_load;
        endcase
        mul_product = prod;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8] = 8'($urandom);
            req_b[8*i +: 8] = 8'($urandom);
        end
    endtask

    bit rst_fired = 1'b0;

    task automatic drive_stimulus();
        rst = 1'b0;
        if (cyc < 4) begin
            rst = 1'b1;
            req = '0;
        end else if (cyc < 40) begin
            fixed_lat = 8;
            if (cyc == 4) begin
                req = 4'b0001;
                req_a[7:0] = 8'd12;
                req_b[7:0] = 8'd13;
            end else begin
                req = req & ~gnt;
            end
        end else if (cyc < 100) begin
            fixed_lat = -1;
            req = '1;
            for (int i = 0; i < NREQ; i++) begin
                req_a[8*i +: 8] = 8'(i + 2);
                req_b[8*i +: 8] = 8'd255;
            end
        end else if (cyc < 140) begin
            if (cyc == 100) req = 4'b0100;
            else if (cyc == 120) req = 4'b0101;
            else req = req & ~gnt;
        end else if (cyc < 300) begin
            mode = (cyc < 220) ? M_HANG : M_NORMAL;
            if (cyc == 140) req = 4'b0010;
            else if (cyc == 220) req = 4'b1000;
            else req = req & ~gnt;
        end else if (cyc < 340) begin
            mode = M_STALE;
            if (cyc == 300) begin
                req = 4'b0001;
                req_a[7:0] = 8'd255;
                req_b[7:0] = 8'd255;
            end else begin
                req = req & ~gnt;
            end
        end else if (cyc < 400) begin
            mode = M_NORMAL;
            fixed_lat = 20;
            if (cyc == 340) req = 4'b0001;
            else if (cyc == 370) req = 4'b0010;
            else req = req & ~gnt;
            if (!rst_fired && m_active && m_j == 3) begin
                rst = 1'b1;
                rst_fired = 1'b1;
            end
        end else begin
            fixed_lat = -1;
            if (cyc % 150 == 0) begin
                case ($urandom_range(0, 9))
                    0:       mode = M_HANG;
                    1, 2:    mode = M_STALE;
                    default: mode = M_NORMAL;
                endcase
            end
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
            if ($urandom_range(0, 2) == 0) req = NREQ'($urandom);
            else req = req & ~gnt;
            rand_operands();
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_a = '0;
        req_b = '0;
        mul_ready = 1'b0;
        mul_product = '0;
        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            model_step();
            #1;
            check("gnt",         32'(gnt),         32'(e_gnt));
            check("done",        32'(done),        32'(e_done));
            check("result",      32'(result),      32'(e_result));
            check("timeout_err", 32'(timeout_err), 32'(e_terr));
            check("busy",        32'(busy),        32'(e_busy));
            check("mul_load",    32'(mul_load),    32'(e_load));
            check("mul_a",       32'(mul_a),       32'(e_a));
            check("mul_b",       32'(mul_b),       32'(e_b));
            mul_step();
            drive_stimulus();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
